// File: rtl/spi_slave.sv
// SPI target (CPOL=1, LSB first) oversampled in the local clock domain.
// Full-duplex byte exchange per ss-low frame, with rx valid/overrun and tx holding-register flow control.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_overrun,
    input  logic                  rx_ack,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_dly_q;
    logic                   ss_dly_q;

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_fall;
    logic ss_fall;
    logic ss_rise;

    // Synchronisers come out of reset at the idle level so no false edge is seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '1;
            ss_sync_q   <= '1;
            mosi_sync_q <= '1;
            sclk_dly_q  <= 1'b1;
            ss_dly_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chain shifts by one stage per clock.
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            ss_dly_q    <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_dly_q & ~sclk_s;
    assign ss_fall   = ss_dly_q & ~ss_s;
    assign ss_rise   = ~ss_dly_q & ss_s;

    // ------------------------------------------------------------------
    // Frame FSM and datapath
    // ------------------------------------------------------------------
    state_e                state_q,      state_d;
    logic [CNT_W-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q,   tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q,   rx_shift_d;
    logic [DATA_WIDTH-1:0] hold_q,       hold_d;
    logic                  tx_ready_q,   tx_ready_d;
    logic [DATA_WIDTH-1:0] rx_data_q,    rx_data_d;
    logic                  rx_valid_q,   rx_valid_d;
    logic                  rx_overrun_q, rx_overrun_d;
    logic                  frame_err_q,  frame_err_d;
    logic                  pending_q,    pending_d;
    logic                  capture;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            tx_shift_q   <= '1;
            rx_shift_q   <= '0;
            hold_q       <= '0;
            tx_ready_q   <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            hold_q       <= hold_d;
            tx_ready_q   <= tx_ready_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            frame_err_q  <= frame_err_d;
            pending_q    <= pending_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (which would infer a latch).
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        hold_d      = hold_q;
        tx_ready_d  = tx_ready_q;
        rx_data_d   = rx_data_q;
        frame_err_d = 1'b0;
        capture     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    tx_shift_d = tx_ready_q ? '1 : hold_q;
                    tx_ready_d = 1'b1;
                end
            end
            SHIFT: begin
                // The final bit wins over a coincident ss rise; any other ss rise aborts the frame.
                if (sclk_fall && bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    rx_shift_d = {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
                    tx_shift_d = {1'b1, tx_shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d  = CNT_W'(DATA_WIDTH);
                    rx_data_d  = {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
                    capture    = 1'b1;
                    state_d    = DONE;
                end else if (ss_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (sclk_fall) begin
                    rx_shift_d = {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
                    tx_shift_d = {1'b1, tx_shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Level test so a frame whose ss rose with the last sclk fall still leaves DONE.
                if (ss_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Applied after the frame-start copy: a same-clock load lands for the next frame.
        if (tx_load && tx_ready_q) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end
    end

    // Rx handshake: an ack in the capture clock consumes the old byte, so no overrun.
    always_comb begin
        rx_valid_d   = capture;
        rx_overrun_d = capture & pending_q & ~rx_ack;
        pending_d    = capture | (pending_q & ~rx_ack);
    end

    assign miso       = (state_q == SHIFT) ? tx_shift_q[0] : 1'b1;
    assign miso_oe    = (state_q != IDLE);
    assign busy       = (state_q == SHIFT);
    assign tx_ready   = tx_ready_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_overrun_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bench-side SPI master plus a frame-level model
// (expected byte queue, pending flag, last byte) checked every clock, and directed literals per scenario.
module tb_spi_slave;

    logic       clock;
    logic       reset;
    logic       sclk;
    logic       ss;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       rx_ack;
    logic       frame_err;
    logic       busy;

    spi_slave #(
        .DATA_WIDTH (8),
        .SYNC_STAGES(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sclk      (sclk),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_overrun(rx_overrun),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: bytes the master completed, the rx pending flag, the last delivered byte.
    logic [7:0] exp_q[$];
    logic [7:0] last_m = 8'h00;
    logic       pend_m = 1'b0;
    int         cnt_valid = 0;
    int         cnt_ovr   = 0;
    int         cnt_ferr  = 0;

    always @(negedge clock) begin
        logic [7:0] exp_b;
        if (reset) begin
            last_m = 8'h00;
            pend_m = 1'b0;
            exp_q.delete();
        end else begin
            if (rx_valid) begin
                cnt_valid++;
                check("rx_valid_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("rx_data_model", 32'(rx_data), 32'(exp_b));
                    last_m = exp_b;
                end
                check("rx_overrun_model", 32'(rx_overrun), 32'(pend_m));
                pend_m = 1'b1;
            end else begin
                check("rx_data_hold", 32'(rx_data), 32'(last_m));
                check("rx_overrun_quiet", 32'(rx_overrun), 32'd0);
                if (rx_ack) pend_m = 1'b0;
            end
            if (rx_overrun) cnt_ovr++;
            if (frame_err) cnt_ferr++;
            if (!miso_oe) check("miso_idle_high", 32'(miso), 32'd1);
            check("busy_implies_oe", 32'(busy & ~miso_oe), 32'd0);
            check("ferr_excl_valid", 32'(frame_err & rx_valid), 32'd0);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
    endtask

    task automatic ack_rx();
        rx_ack = 1'b1;
        wait_clk(1);
        rx_ack = 1'b0;
    endtask

    // Master: mosi set while sclk high, miso sampled just before each falling edge.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input int half,
                            input bit ss_with_last, output logic [7:0] mi);
        mi = 8'hFF;
        ss = 1'b0;
        wait_clk(6);
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[i];
            wait_clk(half);
            mi[i] = miso;
            if (ss_with_last && i == nbits - 1) ss = 1'b1;
            sclk = 1'b0;
            wait_clk(half);
            sclk = 1'b1;
        end
        wait_clk(half);
        ss   = 1'b1;
        mosi = 1'b1;
        wait_clk(8);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"},       32'(miso),       32'd1);
        check({tag, "_miso_oe"},    32'(miso_oe),    32'd0);
        check({tag, "_tx_ready"},   32'(tx_ready),   32'd1);
        check({tag, "_rx_data"},    32'(rx_data),    32'd0);
        check({tag, "_rx_valid"},   32'(rx_valid),   32'd0);
        check({tag, "_rx_overrun"}, 32'(rx_overrun), 32'd0);
        check({tag, "_frame_err"},  32'(frame_err),  32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    initial begin
        logic [7:0] mi;
        int v0, o0, f0;

        reset   = 1'b1;
        sclk    = 1'b1;
        ss      = 1'b1;
        mosi    = 1'b1;
        tx_data = 8'h00;
        tx_load = 1'b0;
        rx_ack  = 1'b0;
        wait_clk(3);
        check_reset_values("rst_held");
        reset = 1'b0;
        wait_clk(4);
        check_reset_values("rst_released");

        // 1: preloaded A5 returned while 3C received at half-period 4; a second load is refused.
        load_tx(8'hA5);
        check("t1_tx_ready_after_load", 32'(tx_ready), 32'd0);
        load_tx(8'h5A);
        v0 = cnt_valid; o0 = cnt_ovr; f0 = cnt_ferr;
        exp_q.push_back(8'h3C);
        spi_xfer(8'h3C, 8, 4, 1'b0, mi);
        check("t1_master_rx", 32'(mi), 32'hA5);
        check("t1_rx_data", 32'(rx_data), 32'h3C);
        check("t1_valid_pulses", 32'(cnt_valid - v0), 32'd1);
        check("t1_overrun_pulses", 32'(cnt_ovr - o0), 32'd0);
        check("t1_ferr_pulses", 32'(cnt_ferr - f0), 32'd0);
        check("t1_tx_ready_after_frame", 32'(tx_ready), 32'd1);
        ack_rx();

        // 2: empty holding register -> FF on miso.
        v0 = cnt_valid;
        exp_q.push_back(8'h81);
        spi_xfer(8'h81, 8, 4, 1'b0, mi);
        check("t2_master_rx", 32'(mi), 32'hFF);
        check("t2_rx_data", 32'(rx_data), 32'h81);
        check("t2_valid_pulses", 32'(cnt_valid - v0), 32'd1);
        ack_rx();

        // 3: two frames without ack -> exactly one overrun, latest byte kept.
        v0 = cnt_valid; o0 = cnt_ovr;
        exp_q.push_back(8'h11);
        spi_xfer(8'h11, 8, 4, 1'b0, mi);
        check("t3_overrun_first", 32'(cnt_ovr - o0), 32'd0);
        exp_q.push_back(8'h22);
        spi_xfer(8'h22, 8, 4, 1'b0, mi);
        check("t3_rx_data", 32'(rx_data), 32'h22);
        check("t3_valid_pulses", 32'(cnt_valid - v0), 32'd2);
        check("t3_overrun_pulses", 32'(cnt_ovr - o0), 32'd1);
        ack_rx();

        // 4: ss raised after 5 falls -> frame error, rx_data untouched.
        v0 = cnt_valid; f0 = cnt_ferr;
        spi_xfer(8'h5A, 5, 4, 1'b0, mi);
        check("t4_ferr_pulses", 32'(cnt_ferr - f0), 32'd1);
        check("t4_valid_pulses", 32'(cnt_valid - v0), 32'd0);
        check("t4_rx_data", 32'(rx_data), 32'h22);
        check("t4_miso_oe", 32'(miso_oe), 32'd0);

        // 5: reset after 3 bits, then a clean frame.
        v0 = cnt_valid; f0 = cnt_ferr;
        load_tx(8'h77);
        ss = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 3; i++) begin
            mosi = i[0];
            wait_clk(4);
            sclk = 1'b0;
            wait_clk(4);
            sclk = 1'b1;
        end
        check("t5_busy_mid_frame", 32'(busy), 32'd1);
        check("t5_oe_mid_frame", 32'(miso_oe), 32'd1);
        reset = 1'b1;
        ss    = 1'b1;
        mosi  = 1'b1;
        wait_clk(1);
        check_reset_values("t5_in_reset");
        reset = 1'b0;
        wait_clk(6);
        check_reset_values("t5_after_reset");
        check("t5_no_valid", 32'(cnt_valid - v0), 32'd0);
        check("t5_no_ferr", 32'(cnt_ferr - f0), 32'd0);
        v0 = cnt_valid; o0 = cnt_ovr;
        exp_q.push_back(8'hC3);
        spi_xfer(8'hC3, 8, 4, 1'b0, mi);
        check("t5_rx_data", 32'(rx_data), 32'hC3);
        check("t5_master_rx", 32'(mi), 32'hFF);
        check("t5_valid_pulses", 32'(cnt_valid - v0), 32'd1);
        check("t5_overrun_pulses", 32'(cnt_ovr - o0), 32'd0);
        ack_rx();

        // 6: fastest legal sclk (clock = 4x sclk).
        v0 = cnt_valid; f0 = cnt_ferr;
        load_tx(8'h96);
        exp_q.push_back(8'h6B);
        spi_xfer(8'h6B, 8, 2, 1'b0, mi);
        check("t6_rx_data", 32'(rx_data), 32'h6B);
        check("t6_master_rx", 32'(mi), 32'h96);
        check("t6_valid_pulses", 32'(cnt_valid - v0), 32'd1);
        check("t6_ferr_pulses", 32'(cnt_ferr - f0), 32'd0);
        ack_rx();

        // 7: ss rises together with the last sclk fall -> frame still completes.
        v0 = cnt_valid; f0 = cnt_ferr;
        exp_q.push_back(8'hE7);
        spi_xfer(8'hE7, 8, 4, 1'b1, mi);
        check("t7_rx_data", 32'(rx_data), 32'hE7);
        check("t7_valid_pulses", 32'(cnt_valid - v0), 32'd1);
        check("t7_ferr_pulses", 32'(cnt_ferr - f0), 32'd0);
        check("t7_miso_oe", 32'(miso_oe), 32'd0);
        check("t7_queue_drained", 32'(exp_q.size()), 32'd0);
        ack_rx();

        wait_clk(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
